// File: rtl/fbuf_arbiter.sv
// Frame-buffer arbiter: camera capture FSM plus a single-port RAM shared by
// camera writes (fixed priority) and round-robin VGA / processor reads.
module fbuf_arbiter #(
  parameter int unsigned WIDTH  = 176,
  parameter int unsigned HEIGHT = 144,
  parameter int unsigned AW     = 15
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          CAPTURE_EN,
  input  logic          FRAME_START,
  input  logic          FRAME_END,
  input  logic          CAM_REQ,
  input  logic [7:0]    CAM_X,
  input  logic [7:0]    CAM_Y,
  input  logic [7:0]    CAM_DATA,
  output logic          CAM_ACK,
  input  logic          VGA_REQ,
  input  logic [7:0]    VGA_X,
  input  logic [7:0]    VGA_Y,
  output logic          VGA_ACK,
  output logic          VGA_RVALID,
  output logic [7:0]    VGA_RDATA,
  input  logic          PROC_REQ,
  input  logic [7:0]    PROC_X,
  input  logic [7:0]    PROC_Y,
  output logic          PROC_ACK,
  output logic          PROC_RVALID,
  output logic [7:0]    PROC_RDATA,
  output logic [AW-1:0] MEM_ADDR,
  output logic [7:0]    MEM_WDATA,
  output logic          MEM_WE,
  input  logic [7:0]    MEM_RDATA,
  output logic [1:0]    STATE,
  output logic [7:0]    FRAME_COUNT
);

  localparam int unsigned PROD_W   = 17;
  localparam logic [8:0]  WIDTH_L  = 9'(WIDTH);
  localparam logic [8:0]  HEIGHT_L = 9'(HEIGHT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    CAPTURING = 2'd2,
    DONE      = 2'd3
  } cap_state_e;

  cap_state_e    state_q, state_d;
  logic [7:0]    fc_q, fc_d;
  logic          rr_q, rr_d;          // 1: PROC is favoured on the next conflict
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          rd_vga_p1_q, rd_vga_p1_d;
  logic          rd_proc_p1_q, rd_proc_p1_d;
  logic          rd_oob_p1_q, rd_oob_p1_d;
  logic          vga_rvalid_q, proc_rvalid_q;
  logic          rd_oob_p2_q;

  logic          cam_gnt, vga_gnt, proc_gnt;
  logic [7:0]    sel_x, sel_y;
  logic          in_range;
  logic [PROD_W-1:0] addr_full;

  // Y*WIDTH as a sum of shifted copies of Y; no multiplier is inferred.
  function automatic logic [PROD_W-1:0] row_base(input logic [7:0] y);
    logic [PROD_W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (WIDTH_L[i]) acc = acc + (PROD_W'(y) << i);
    end
    return acc;
  endfunction

  // Grant: camera always wins; VGA/PROC share by round-robin pointer.
  always_comb begin
    cam_gnt  = RESET_N & CAM_REQ;
    vga_gnt  = RESET_N & ~CAM_REQ & VGA_REQ  & (~PROC_REQ | ~rr_q);
    proc_gnt = RESET_N & ~CAM_REQ & PROC_REQ & (~VGA_REQ  |  rr_q);
  end

  assign CAM_ACK  = cam_gnt;
  assign VGA_ACK  = vga_gnt;
  assign PROC_ACK = proc_gnt;

  always_comb begin
    sel_x = PROC_X;
    sel_y = PROC_Y;
    if (cam_gnt) begin
      sel_x = CAM_X;
      sel_y = CAM_Y;
    end else if (vga_gnt) begin
      sel_x = VGA_X;
      sel_y = VGA_Y;
    end
    in_range  = ({1'b0, sel_x} < WIDTH_L) && ({1'b0, sel_y} < HEIGHT_L);
    addr_full = row_base(sel_y) + PROD_W'(sel_x);
  end

  // Capture FSM next state and completed-frame counter.
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    case (state_q)
      IDLE:      if (CAPTURE_EN) state_d = ARMED;
      ARMED: begin
        if (!CAPTURE_EN)      state_d = IDLE;
        else if (FRAME_START) state_d = CAPTURING;
      end
      CAPTURING: begin
        if (FRAME_END) begin
          state_d = DONE;
          fc_d    = fc_q + 8'd1;
        end
      end
      DONE:      state_d = CAPTURE_EN ? ARMED : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Memory port and read pipeline next state.
  always_comb begin
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    rr_d         = rr_q;
    rd_vga_p1_d  = vga_gnt;
    rd_proc_p1_d = proc_gnt;
    rd_oob_p1_d  = (vga_gnt | proc_gnt) & ~in_range;
    if (vga_gnt)       rr_d = 1'b1;
    else if (proc_gnt) rr_d = 1'b0;
    if (cam_gnt) begin
      if ((state_q == CAPTURING) && in_range) begin
        mem_addr_d  = AW'(addr_full);
        mem_wdata_d = CAM_DATA;
        mem_we_d    = 1'b1;
      end
    end else if ((vga_gnt | proc_gnt) && in_range) begin
      mem_addr_d = AW'(addr_full);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      fc_q          <= 8'd0;
      rr_q          <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= 8'd0;
      mem_we_q      <= 1'b0;
      rd_vga_p1_q   <= 1'b0;
      rd_proc_p1_q  <= 1'b0;
      rd_oob_p1_q   <= 1'b0;
      vga_rvalid_q  <= 1'b0;
      proc_rvalid_q <= 1'b0;
      rd_oob_p2_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      fc_q          <= fc_d;
      rr_q          <= rr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      rd_vga_p1_q   <= rd_vga_p1_d;
      rd_proc_p1_q  <= rd_proc_p1_d;
      rd_oob_p1_q   <= rd_oob_p1_d;
      vga_rvalid_q  <= rd_vga_p1_q;
      proc_rvalid_q <= rd_proc_p1_q;
      rd_oob_p2_q   <= rd_oob_p1_q;
    end
  end

  // RAM data arrives in the cycle RVALID is high, so it is steered, not registered.
  assign VGA_RVALID  = vga_rvalid_q;
  assign PROC_RVALID = proc_rvalid_q;
  assign VGA_RDATA   = (vga_rvalid_q  && !rd_oob_p2_q) ? MEM_RDATA : 8'h00;
  assign PROC_RDATA  = (proc_rvalid_q && !rd_oob_p2_q) ? MEM_RDATA : 8'h00;

  assign MEM_ADDR    = mem_addr_q;
  assign MEM_WDATA   = mem_wdata_q;
  assign MEM_WE      = mem_we_q;
  assign STATE       = state_q;
  assign FRAME_COUNT = fc_q;

endmodule

// File: tb/tb_fbuf_arbiter.sv
// Directed bench for fbuf_arbiter: arbitration table, capture FSM, reads and reset.
module tb_fbuf_arbiter;

  localparam int unsigned AW = 15;

  logic          CLK, RESET_N, CAPTURE_EN, FRAME_START, FRAME_END;
  logic          CAM_REQ, VGA_REQ, PROC_REQ;
  logic [7:0]    CAM_X, CAM_Y, CAM_DATA, VGA_X, VGA_Y, PROC_X, PROC_Y;
  logic          CAM_ACK, VGA_ACK, VGA_RVALID, PROC_ACK, PROC_RVALID, MEM_WE;
  logic [7:0]    VGA_RDATA, PROC_RDATA, MEM_WDATA, MEM_RDATA, FRAME_COUNT;
  logic [AW-1:0] MEM_ADDR;
  logic [1:0]    STATE;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_fc;

  logic [7:0] ram [0:(1<<AW)-1];

  typedef struct packed {
    logic [2:0] req;   // {cam, vga, proc}
    logic [2:0] ack;
  } vec_t;
  vec_t tbl [13];

  fbuf_arbiter #(.WIDTH(176), .HEIGHT(144), .AW(AW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CAPTURE_EN(CAPTURE_EN),
    .FRAME_START(FRAME_START), .FRAME_END(FRAME_END),
    .CAM_REQ(CAM_REQ), .CAM_X(CAM_X), .CAM_Y(CAM_Y), .CAM_DATA(CAM_DATA),
    .CAM_ACK(CAM_ACK),
    .VGA_REQ(VGA_REQ), .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_ACK(VGA_ACK),
    .VGA_RVALID(VGA_RVALID), .VGA_RDATA(VGA_RDATA),
    .PROC_REQ(PROC_REQ), .PROC_X(PROC_X), .PROC_Y(PROC_Y), .PROC_ACK(PROC_ACK),
    .PROC_RVALID(PROC_RVALID), .PROC_RDATA(PROC_RDATA),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE),
    .MEM_RDATA(MEM_RDATA), .STATE(STATE), .FRAME_COUNT(FRAME_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous single-port RAM, one-cycle read latency.
  always @(posedge CLK) begin
    if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
    MEM_RDATA <= ram[MEM_ADDR];
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(negedge CLK);
  endtask

  task automatic cam_op(input logic [7:0] x, input logic [7:0] y, input logic [7:0] d);
    CAM_REQ = 1'b1; CAM_X = x; CAM_Y = y; CAM_DATA = d;
    #1 chk("cam_ack", 32'(CAM_ACK), 1);
    step;
    CAM_REQ = 1'b0;
  endtask

  task automatic vga_op(input logic [7:0] x, input logic [7:0] y);
    VGA_REQ = 1'b1; VGA_X = x; VGA_Y = y;
    #1 chk("vga_ack", 32'(VGA_ACK), 1);
    step;
    VGA_REQ = 1'b0;
  endtask

  task automatic proc_op(input logic [7:0] x, input logic [7:0] y);
    PROC_REQ = 1'b1; PROC_X = x; PROC_Y = y;
    #1 chk("proc_ack", 32'(PROC_ACK), 1);
    step;
    PROC_REQ = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(STATE), 0);
    chk({tag, "_fc"}, 32'(FRAME_COUNT), 0);
    chk({tag, "_addr"}, 32'(MEM_ADDR), 0);
    chk({tag, "_wdata"}, 32'(MEM_WDATA), 0);
    chk({tag, "_we"}, 32'(MEM_WE), 0);
    chk({tag, "_acks"}, 32'({CAM_ACK, VGA_ACK, PROC_ACK}), 0);
    chk({tag, "_rvalid"}, 32'({VGA_RVALID, PROC_RVALID}), 0);
    chk({tag, "_rdata"}, 32'({VGA_RDATA, PROC_RDATA}), 0);
  endtask

  initial begin
    RESET_N = 1'b0; CAPTURE_EN = 1'b0; FRAME_START = 1'b0; FRAME_END = 1'b0;
    CAM_REQ = 1'b1; VGA_REQ = 1'b1; PROC_REQ = 1'b0;
    CAM_X = 8'd0; CAM_Y = 8'd0; CAM_DATA = 8'd0;
    VGA_X = 8'd0; VGA_Y = 8'd0; PROC_X = 8'd0; PROC_Y = 8'd0;
    exp_fc = 8'd0;

    tbl[0]  = '{req: 3'b111, ack: 3'b100};
    tbl[1]  = '{req: 3'b111, ack: 3'b100};
    tbl[2]  = '{req: 3'b111, ack: 3'b100};
    tbl[3]  = '{req: 3'b111, ack: 3'b100};
    tbl[4]  = '{req: 3'b011, ack: 3'b010};
    tbl[5]  = '{req: 3'b011, ack: 3'b001};
    tbl[6]  = '{req: 3'b011, ack: 3'b010};
    tbl[7]  = '{req: 3'b011, ack: 3'b001};
    tbl[8]  = '{req: 3'b001, ack: 3'b001};
    tbl[9]  = '{req: 3'b011, ack: 3'b010};
    tbl[10] = '{req: 3'b010, ack: 3'b010};
    tbl[11] = '{req: 3'b011, ack: 3'b001};
    tbl[12] = '{req: 3'b000, ack: 3'b000};

    // Requests held during reset must not be acknowledged.
    step; step;
    chk_reset_outputs("rst");
    CAM_REQ = 1'b0; VGA_REQ = 1'b0;
    RESET_N = 1'b1;
    step;

    // Arbitration table in IDLE: camera grants are dropped.
    for (int i = 0; i < 13; i++) begin
      if (i > 0) chk("tbl_we", 32'(MEM_WE), 0);
      {CAM_REQ, VGA_REQ, PROC_REQ} = tbl[i].req;
      #1 chk($sformatf("tbl_ack%0d", i), 32'({CAM_ACK, VGA_ACK, PROC_ACK}), 32'(tbl[i].ack));
      step;
    end
    {CAM_REQ, VGA_REQ, PROC_REQ} = 3'b000;
    step; step;

    // Arm and start capture.
    CAPTURE_EN = 1'b1;
    step;
    chk("armed", 32'(STATE), 1);
    FRAME_START = 1'b1;
    step;
    FRAME_START = 1'b0;
    chk("capturing", 32'(STATE), 2);

    cam_op(8'd175, 8'd143, 8'hE3);
    chk("wr_addr", 32'(MEM_ADDR), 25343);
    chk("wr_data", 32'(MEM_WDATA), 32'hE3);
    chk("wr_we", 32'(MEM_WE), 1);
    step;
    chk("wr_we_once", 32'(MEM_WE), 0);

    cam_op(8'd176, 8'd0, 8'h11);
    chk("oob_wr_we", 32'(MEM_WE), 0);
    chk("oob_wr_addr", 32'(MEM_ADDR), 25343);

    cam_op(8'd1, 8'd1, 8'h5A);
    chk("wr177_addr", 32'(MEM_ADDR), 177);
    chk("wr177_we", 32'(MEM_WE), 1);

    // Dropping CAPTURE_EN mid-frame does not abort it.
    CAPTURE_EN = 1'b0;
    step;
    chk("no_abort", 32'(STATE), 2);
    CAPTURE_EN = 1'b1;
    FRAME_END = 1'b1;
    step;
    FRAME_END = 1'b0;
    exp_fc = exp_fc + 8'd1;
    chk("done", 32'(STATE), 3);
    chk("fc1", 32'(FRAME_COUNT), 32'(exp_fc));
    step;
    chk("rearm", 32'(STATE), 1);

    // In-range read returns RAM data two cycles after the grant.
    vga_op(8'd1, 8'd1);
    chk("rd_addr", 32'(MEM_ADDR), 177);
    chk("rd_rv_t1", 32'(VGA_RVALID), 0);
    step;
    chk("rd_rv_t2", 32'(VGA_RVALID), 1);
    chk("rd_data_t2", 32'(VGA_RDATA), 32'h5A);
    step;
    chk("rd_rv_t3", 32'(VGA_RVALID), 0);
    chk("rd_data_t3", 32'(VGA_RDATA), 0);

    // Out-of-range read: address held, zero data with RVALID.
    proc_op(8'd200, 8'd0);
    chk("oob_rd_addr", 32'(MEM_ADDR), 177);
    step;
    chk("oob_rd_rv", 32'(PROC_RVALID), 1);
    chk("oob_rd_data", 32'(PROC_RDATA), 0);
    chk("oob_rd_vga", 32'(VGA_RVALID), 0);

    // ARMED with enable low returns to IDLE.
    CAPTURE_EN = 1'b0;
    step;
    chk("disarm", 32'(STATE), 0);
    CAPTURE_EN = 1'b1;
    step;
    chk("arm2", 32'(STATE), 1);

    // Simultaneous START/END while capturing: END wins; START ignored in DONE.
    FRAME_START = 1'b1;
    step;
    chk("cap2", 32'(STATE), 2);
    FRAME_END = 1'b1;
    step;
    FRAME_END = 1'b0;
    exp_fc = exp_fc + 8'd1;
    chk("both_done", 32'(STATE), 3);
    step;
    FRAME_START = 1'b0;
    chk("start_in_done", 32'(STATE), 1);

    // Remaining frames to wrap the counter after 256 in total.
    for (int k = 0; k < 254; k++) begin
      FRAME_START = 1'b1;
      step;
      FRAME_START = 1'b0;
      chk("loop_cap", 32'(STATE), 2);
      FRAME_END = 1'b1;
      step;
      FRAME_END = 1'b0;
      exp_fc = exp_fc + 8'd1;
      chk("loop_done", 32'(STATE), 3);
      step;
      chk("loop_arm", 32'(STATE), 1);
    end
    chk("fc_wrap", 32'(FRAME_COUNT), 32'(exp_fc));
    chk("fc_zero", 32'(FRAME_COUNT), 0);

    // Reset one cycle after a PROC grant discards the read.
    CAPTURE_EN = 1'b0;
    proc_op(8'd1, 8'd1);
    RESET_N = 1'b0;
    #1 chk_reset_outputs("midrst");
    step;
    RESET_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step;
      chk("post_rst_rv", 32'(PROC_RVALID), 0);
    end

    // Pointer reset favours VGA.
    VGA_REQ = 1'b1; PROC_REQ = 1'b1;
    #1 chk("rr_reset", 32'({VGA_ACK, PROC_ACK}), 32'b10);
    step;
    VGA_REQ = 1'b0; PROC_REQ = 1'b0;
    step;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
